// File: rtl/ripple_count_checker.sv
// Locks onto a +1 mod 2^WIDTH count stream and flags deviations. Outputs react one cycle after the sampling edge.
// There is no backpressure: samples are taken only when q_valid is high, and every valid sample is consumed.
module ripple_count_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_M = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_valid,
    input  logic             clear,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] expected
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(UNLOCK_M + 1);

    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [GW-1:0]    ONE_G    = GW'(1);
    localparam logic [BW-1:0]    ONE_B    = BW'(1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [GW-1:0]    LOCK_V   = GW'(LOCK_N);
    localparam logic [BW-1:0]    UNLOCK_V = BW'(UNLOCK_M);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             has_prev_q, has_prev_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [GW-1:0]    good_run_q, good_run_d;
    logic [BW-1:0]    bad_run_q, bad_run_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [WIDTH-1:0] last_inc;
    logic             match;

    assign last_inc = last_q + ONE_W;
    assign match    = has_prev_q && (q_in == last_inc);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= HUNT;
            has_prev_q <= 1'b0;
            last_q     <= '0;
            good_run_q <= '0;
            bad_run_q  <= '0;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            has_prev_q <= has_prev_d;
            last_q     <= last_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        has_prev_d = has_prev_q;
        last_d     = last_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        error_d    = 1'b0;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;

        if (q_valid) begin
            // Both match and mismatch resync to the observed value.
            last_d     = q_in;
            has_prev_d = 1'b1;
            if (state_q == HUNT) begin
                good_run_d = match ? (good_run_q + ONE_G) : '0;
                if (good_run_d == LOCK_V) begin
                    state_d   = LOCKED;
                    bad_run_d = '0;
                end
            end else begin
                if (match) begin
                    bad_run_d = '0;
                    if ((q_in == '0) && (wrap_cnt_q != '1)) begin
                        wrap_cnt_d = wrap_cnt_q + ONE_C;
                    end
                end else begin
                    error_d   = 1'b1;
                    bad_run_d = bad_run_q + ONE_B;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ONE_C;
                    end
                    if (bad_run_d == UNLOCK_V) begin
                        state_d    = HUNT;
                        good_run_d = '0;
                    end
                end
            end
        end

        // Clear beats a same-edge increment; the error pulse is unaffected.
        if (clear) begin
            err_cnt_d  = '0;
            wrap_cnt_d = '0;
        end
    end

    always_comb begin
        locked     = (state_q == LOCKED);
        error      = error_q;
        err_count  = err_cnt_q;
        wrap_count = wrap_cnt_q;
        expected   = has_prev_q ? last_inc : '0;
    end

endmodule

// File: tb/tb_ripple_count_checker.sv
// Bench for ripple_count_checker: directed vector table, saturation/clear/reset sequence, randomized run vs reference model.
module tb_ripple_count_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       q_valid = 1'b0;
    logic       clear = 1'b0;

    logic       lk_a, er_a, lk_b, er_b;
    logic [7:0] ec_a, wc_a;
    logic [1:0] ec_b, wc_b;
    logic [3:0] ex_a, ex_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ripple_count_checker u_dut (
        .clk(clk), .reset(rst_n), .q_in(q_in), .q_valid(q_valid), .clear(clear),
        .locked(lk_a), .error(er_a), .err_count(ec_a), .wrap_count(wc_a), .expected(ex_a)
    );

    ripple_count_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(rst_n), .q_in(q_in), .q_valid(q_valid), .clear(clear),
        .locked(lk_b), .error(er_b), .err_count(ec_b), .wrap_count(wc_b), .expected(ex_b)
    );

    typedef struct {
        logic rst_n;
        logic vld;
        int   q;
        logic clr;
        int   e_lock;
        int   e_err;
        int   e_ec;
        int   e_wc;
        int   e_exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input int q, input logic c,
                       input int l, input int e, input int ec, input int wc, input int ex);
        vec_t t;
        t.rst_n = r; t.vld = v; t.q = q; t.clr = c;
        t.e_lock = l; t.e_err = e; t.e_ec = ec; t.e_wc = wc; t.e_exp = ex;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input int q, input logic c);
        rst_n = r; q_valid = v; q_in = 4'(q); clear = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model: spec rules with plain integers; two counter ceilings.
    bit m_lock, m_hp, m_err;
    int m_last, m_good, m_bad, m_ec, m_wc, m_ec2, m_wc2;

    function automatic int m_expected();
        return m_hp ? (m_last + 1) % 16 : 0;
    endfunction

    task automatic model(input logic r, input logic v, input int q, input logic c);
        bit hit;
        if (!r) begin
            m_lock = 0; m_hp = 0; m_err = 0; m_last = 0; m_good = 0; m_bad = 0;
            m_ec = 0; m_wc = 0; m_ec2 = 0; m_wc2 = 0;
            return;
        end
        m_err = 0;
        if (v) begin
            hit = m_hp && (q == (m_last + 1) % 16);
            if (!m_lock) begin
                m_good = hit ? m_good + 1 : 0;
                if (m_good == 3) begin m_lock = 1; m_bad = 0; end
            end else if (hit) begin
                m_bad = 0;
                if (q == 0) begin
                    m_wc  = (m_wc  < 255) ? m_wc + 1  : m_wc;
                    m_wc2 = (m_wc2 < 3)   ? m_wc2 + 1 : m_wc2;
                end
            end else begin
                m_err = 1;
                m_ec  = (m_ec  < 255) ? m_ec + 1  : m_ec;
                m_ec2 = (m_ec2 < 3)   ? m_ec2 + 1 : m_ec2;
                m_bad++;
                if (m_bad == 2) begin m_lock = 0; m_good = 0; end
            end
            m_last = q; m_hp = 1;
        end
        if (c) begin m_ec = 0; m_wc = 0; m_ec2 = 0; m_wc2 = 0; end
    endtask

    initial begin
        // Lock onto 5,6,7,8 under a reset that ignores valid input
        for (int i = 0; i < 5; i++) add(0, 1, 7, 0, 0, 0, 0, 0, 0);
        add(1, 1, 5, 0,  0, 0, 0, 0, 6);
        add(1, 1, 6, 0,  0, 0, 0, 0, 7);
        add(1, 1, 7, 0,  0, 0, 0, 0, 8);
        add(1, 1, 8, 0,  1, 0, 0, 0, 9);
        // Wrap while locked
        add(0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(1, 1, 10, 0, 0, 0, 0, 0, 11);
        add(1, 1, 11, 0, 0, 0, 0, 0, 12);
        add(1, 1, 12, 0, 0, 0, 0, 0, 13);
        add(1, 1, 13, 0, 1, 0, 0, 0, 14);
        add(1, 1, 14, 0, 1, 0, 0, 0, 15);
        add(1, 1, 15, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0,  1, 0, 0, 1, 1);
        add(1, 1, 1, 0,  1, 0, 0, 1, 2);
        // Single mismatch with resync
        add(1, 1, 2, 0,  1, 0, 0, 1, 3);
        add(1, 1, 3, 0,  1, 0, 0, 1, 4);
        add(1, 1, 9, 0,  1, 1, 1, 1, 10);
        add(1, 1, 10, 0, 1, 0, 1, 1, 11);
        // Two mismatches unlock, then relock
        add(0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(1, 1, 0, 0,  0, 0, 0, 0, 1);
        add(1, 1, 1, 0,  0, 0, 0, 0, 2);
        add(1, 1, 2, 0,  0, 0, 0, 0, 3);
        add(1, 1, 3, 0,  1, 0, 0, 0, 4);
        add(1, 1, 9, 0,  1, 1, 1, 0, 10);
        add(1, 1, 3, 0,  0, 1, 2, 0, 4);
        add(1, 1, 4, 0,  0, 0, 2, 0, 5);
        add(1, 1, 5, 0,  0, 0, 2, 0, 6);
        add(1, 1, 6, 0,  1, 0, 2, 0, 7);
        // Gaps with garbage on q_in, then clear
        add(1, 1, 7, 0,  1, 0, 2, 0, 8);
        add(1, 0, 0, 0,  1, 0, 2, 0, 8);
        add(1, 0, 15, 0, 1, 0, 2, 0, 8);
        add(1, 0, 3, 0,  1, 0, 2, 0, 8);
        add(1, 0, 12, 0, 1, 0, 2, 0, 8);
        add(1, 1, 8, 0,  1, 0, 2, 0, 9);
        add(1, 0, 5, 1,  1, 0, 0, 0, 9);
        add(1, 1, 9, 1,  1, 0, 0, 0, 10);
        // HUNT never flags: repeat and backward step
        add(0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(1, 1, 3, 0,  0, 0, 0, 0, 4);
        add(1, 1, 3, 0,  0, 0, 0, 0, 4);
        add(1, 1, 2, 0,  0, 0, 0, 0, 3);

        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].vld, tbl[i].q, tbl[i].clr);
            chk($sformatf("v%0d locked", i),     int'(lk_a), tbl[i].e_lock);
            chk($sformatf("v%0d error", i),      int'(er_a), tbl[i].e_err);
            chk($sformatf("v%0d err_count", i),  int'(ec_a), tbl[i].e_ec);
            chk($sformatf("v%0d wrap_count", i), int'(wc_a), tbl[i].e_wc);
            chk($sformatf("v%0d expected", i),   int'(ex_a), tbl[i].e_exp);
        end

        // Saturation at CNT_W=2, clear racing a mismatch, reset mid-lock
        begin
            int seq[9] = '{9, 10, 5, 6, 1, 2, 9, 10, 0};
            step(0, 0, 0, 0);
            for (int i = 0; i < 4; i++) step(1, 1, i, 0);
            chk("sat locked", int'(lk_b), 1);
            for (int i = 0; i < 9; i++) begin
                step(1, 1, seq[i], 0);
                chk($sformatf("sat err pulse %0d", i), int'(er_b), (i % 2 == 0) ? 1 : 0);
            end
            chk("sat err_count held", int'(ec_b), 3);
            chk("wide err_count", int'(ec_a), 5);
            chk("sat still locked", int'(lk_b), 1);
            step(1, 1, 1, 0);
            step(1, 1, 5, 1);
            chk("clear+mismatch error", int'(er_b), 1);
            chk("clear+mismatch err_count", int'(ec_b), 0);
            chk("clear+mismatch wide count", int'(ec_a), 0);
            chk("clear+mismatch locked", int'(lk_b), 1);
            chk("clear+mismatch expected", int'(ex_b), 6);
            step(0, 1, 6, 0);
            chk("mid-lock reset locked", int'(lk_b), 0);
            chk("mid-lock reset error", int'(er_b), 0);
            chk("mid-lock reset err_count", int'(ec_b), 0);
            chk("mid-lock reset wrap_count", int'(wc_b), 0);
            chk("mid-lock reset expected", int'(ex_b), 0);
        end

        // Randomized run against the model
        step(0, 0, 0, 0);
        model(0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic r, v, c;
            int   q;
            r = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            v = ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0;
            q = ($urandom_range(0, 9) < 8) ? m_expected() : int'($urandom_range(0, 15));
            c = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
            step(r, v, q, c);
            model(r, v, q, c);
            chk($sformatf("r%0d locked", n),      int'(lk_a), int'(m_lock));
            chk($sformatf("r%0d error", n),       int'(er_a), int'(m_err));
            chk($sformatf("r%0d err_count", n),   int'(ec_a), m_ec);
            chk($sformatf("r%0d wrap_count", n),  int'(wc_a), m_wc);
            chk($sformatf("r%0d expected", n),    int'(ex_a), m_expected());
            chk($sformatf("r%0d sat locked", n),  int'(lk_b), int'(m_lock));
            chk($sformatf("r%0d sat error", n),   int'(er_b), int'(m_err));
            chk($sformatf("r%0d sat err_cnt", n), int'(ec_b), m_ec2);
            chk($sformatf("r%0d sat wrap", n),    int'(wc_b), m_wc2);
            chk($sformatf("r%0d sat expected", n), int'(ex_b), m_expected());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ripple_count_checker.md
Name: ripple_count_checker

Overview:
- Receive-side monitor for the 4-bit ripple counter output: samples a free-running count stream, locks onto the +1 mod 2^WIDTH sequence and flags every deviation.
- Sits beside the counter in lab/self-check designs as its consumer. Reports lock status, per-sample error pulses, saturating error and wrap statistics.

Parameters:
WIDTH, 4, width of observed count
LOCK_N, 3, consecutive correct increments needed to enter LOCKED (>=1)
UNLOCK_M, 2, consecutive mismatches in LOCKED that drop back to HUNT (>=1)
CNT_W, 8, width of err_count and wrap_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 sampled at rising edge of clk resets the block)
q_in  input  WIDTH  observed count value
q_valid  input  1  q_in is sampled this edge when 1
clear  input  1  synchronous clear of err_count and wrap_count
locked  output  1  1 while in LOCKED
error  output  1  one-cycle pulse per mismatching sample in LOCKED
err_count  output  CNT_W  saturating mismatch count
wrap_count  output  CNT_W  saturating count of correct wraps (max->0) while LOCKED
expected  output  WIDTH  next value expected (last+1 mod 2^WIDTH), 0 when no previous sample

Behaviour:
- All outputs registered; every effect is visible the cycle after the sampling edge.
- Reset (reset==0 at edge): state=HUNT, has_prev=0, last=0, good_run=0, bad_run=0, all outputs 0. Highest priority; overrides q_valid and clear, including mid-lock.
- q_valid==0: no state, run or counter change; error=0.
- Compare rule: match when q_in == (last+1) mod 2^WIDTH; wrap 2^WIDTH-1 -> 0 is a match.
- HUNT, on valid sample:
  - If has_prev and match: good_run++. Otherwise good_run=0.
  - last=q_in; has_prev=1.
  - When good_run reaches LOCK_N, go to LOCKED on that same edge and clear bad_run.
  - error is never asserted in HUNT; err_count is never changed in HUNT.
- LOCKED, on valid sample:
  - Match: bad_run=0, last=q_in. If q_in==0, wrap_count++ (saturating).
  - Mismatch: error=1 for one cycle, err_count++ (saturating at 2^CNT_W-1), bad_run++.
  - On mismatch, resync: last=q_in, so expected becomes q_in+1.
  - When bad_run reaches UNLOCK_M, go to HUNT on that edge with good_run=0. last and has_prev are kept, so relock needs LOCK_N further matches.
- locked = (state==LOCKED), registered.
- expected = has_prev ? last+1 : 0.
- Counter saturation: err_count and wrap_count hold at their maximum value and never wrap.
- clear=1: err_count=0 and wrap_count=0. If a mismatch occurs on the same edge, clear wins (count=0) but error still pulses. clear does not affect state, runs, last or expected.
- Multi-bit jumps, repeats (q_in==last) and backward steps are all mismatches.

Test Plan:
1. Reset low 5 cycles, then valid samples 5,6,7,8 -> locked=0 after 5, 6 and 7; locked=1 after 8; expected=9; err_count=0.
2. Lock, then feed 14,15,0,1 -> no error; wrap_count=1 after the sample 0; expected=2 at end.
3. Locked expecting 4, feed 9 then 10 -> error=1 for exactly one cycle after 9; err_count=1; expected=10 then 11; locked stays 1.
4. Locked expecting 4, feed 9 then 3 (UNLOCK_M=2) -> two error pulses, err_count=2, locked=0 after 3. Then 4,5,6 -> locked=1 again after 6.
5. Gaps: locked, samples 2,3 with q_valid low 4 cycles between them, and q_in driven to garbage while q_valid is low -> no error, no state change.
6. CNT_W=2: force 5 mismatches while locked (keeping relocks) -> err_count holds at 3. Then clear=1 coincident with a mismatch -> err_count=0, error=1. Then reset=0 mid-lock -> all outputs 0 on the next cycle.
